// File: rtl/pattern_sequencer.sv
// Pattern playback sequencer: fetches delay/pattern words from memory, shows each
// pattern after its tick delay and scores the user's key response within a window.
module pattern_sequencer #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          WINDOW    = 5
) (
    input  logic              CLOCK10M,
    input  logic              RESET_N,
    input  logic              counter10h,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_valid,
    input  logic [31:0]       read_data,
    input  logic [7:0]        user_key,
    output logic [7:0]        pattern_out,
    output logic              pattern_valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count,
    output logic              fault
);

    localparam int          WIN_W      = $clog2(WINDOW + 1);
    localparam logic [31:0] END_MARKER = 32'h0000_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        DELAY,
        SHOW,
        NEXT
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [23:0]        delay_q, delay_d;
    logic [23:0]        cnt_q, cnt_d;
    logic [7:0]         pat_q, pat_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [7:0]         pattern_out_q, pattern_out_d;
    logic               pvalid_q, pvalid_d;
    logic               mem_rd_q, mem_rd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         hit_q, hit_d;
    logic [7:0]         miss_q, miss_d;
    logic               fault_q, fault_d;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        delay_d       = delay_q;
        cnt_d         = cnt_q;
        pat_d         = pat_q;
        win_d         = win_q;
        pattern_out_d = pattern_out_q;
        pvalid_d      = 1'b0;
        done_d        = 1'b0;
        hit_d         = hit_q;
        miss_d        = miss_q;
        fault_d       = fault_q;

        // abort outranks every other event, including start in IDLE
        if (abort) begin
            state_d       = IDLE;
            pattern_out_d = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d       = FETCH;
                        addr_d        = ADDR_W'(BASE_ADDR);
                        hit_d         = 8'h00;
                        miss_d        = 8'h00;
                        fault_d       = 1'b0;
                        pattern_out_d = 8'h00;
                    end
                end
                FETCH: state_d = WAIT_DATA;
                WAIT_DATA: begin
                    if (mem_valid) begin
                        if (read_data == END_MARKER) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            delay_d = read_data[31:8];
                            pat_d   = read_data[7:0];
                            cnt_d   = 24'd0;
                            state_d = DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (cnt_q == delay_q) begin
                        state_d       = SHOW;
                        pattern_out_d = pat_q;
                        pvalid_d      = 1'b1;
                        win_d         = '0;
                    end else if (counter10h) begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                SHOW: begin
                    // a key match on the same cycle as the window expiring counts as a hit
                    if (user_key == pat_q) begin
                        hit_d   = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
                        state_d = NEXT;
                    end else if (counter10h) begin
                        if (win_q == WIN_W'(WINDOW - 1)) begin
                            miss_d  = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
                            state_d = NEXT;
                        end else begin
                            win_d = win_q + WIN_W'(1);
                        end
                    end
                end
                NEXT: begin
                    if (&addr_q) begin
                        fault_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        mem_rd_d = (state_d == FETCH);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK10M) begin
        if (!RESET_N) begin
            state_q       <= IDLE;
            addr_q        <= ADDR_W'(BASE_ADDR);
            delay_q       <= 24'd0;
            cnt_q         <= 24'd0;
            pat_q         <= 8'h00;
            win_q         <= '0;
            pattern_out_q <= 8'h00;
            pvalid_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            hit_q         <= 8'h00;
            miss_q        <= 8'h00;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            delay_q       <= delay_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            win_q         <= win_d;
            pattern_out_q <= pattern_out_d;
            pvalid_q      <= pvalid_d;
            mem_rd_q      <= mem_rd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            fault_q       <= fault_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_rd        = mem_rd_q;
    assign pattern_out   = pattern_out_q;
    assign pattern_valid = pvalid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: playback, miss window, abort, reset,
// saturation, and address exhaustion on a narrow-address instance.
module tb_pattern_sequencer;

    logic        CLOCK10M   = 1'b0;
    logic        RESET_N    = 1'b0;
    logic        counter10h = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic        mem_valid  = 1'b0;
    logic [31:0] read_data  = 32'h0;
    logic [7:0]  user_key   = 8'h00;

    logic [9:0]  mem_addr;
    logic        mem_rd, pattern_valid, busy, done, fault;
    logic [7:0]  pattern_out, hit_count, miss_count;

    logic        start2     = 1'b0;
    logic        abort2     = 1'b0;
    logic        mem_valid2 = 1'b0;
    logic [31:0] read_data2 = 32'h0;

    logic [1:0]  mem_addr2;
    logic        mem_rd2, pattern_valid2, busy2, done2, fault2;
    logic [7:0]  pattern_out2, hit_count2, miss_count2;

    int checks = 0;
    int errors = 0;

    logic [7:0] pats [3] = '{8'h81, 8'h42, 8'h3C};

    always #50 CLOCK10M = ~CLOCK10M;

    pattern_sequencer #(.ADDR_W(10), .BASE_ADDR(0), .WINDOW(5)) u_dut (
        .CLOCK10M(CLOCK10M), .RESET_N(RESET_N), .counter10h(counter10h),
        .start(start), .abort(abort), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_valid(mem_valid), .read_data(read_data), .user_key(user_key),
        .pattern_out(pattern_out), .pattern_valid(pattern_valid), .busy(busy),
        .done(done), .hit_count(hit_count), .miss_count(miss_count), .fault(fault)
    );

    pattern_sequencer #(.ADDR_W(2), .BASE_ADDR(0), .WINDOW(5)) u_dut2 (
        .CLOCK10M(CLOCK10M), .RESET_N(RESET_N), .counter10h(counter10h),
        .start(start2), .abort(abort2), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
        .mem_valid(mem_valid2), .read_data(read_data2), .user_key(user_key),
        .pattern_out(pattern_out2), .pattern_valid(pattern_valid2), .busy(busy2),
        .done(done2), .hit_count(hit_count2), .miss_count(miss_count2), .fault(fault2)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK10M);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_busy"},  32'(busy), 32'd0);
        check_output({tag, "_rd"},    32'(mem_rd), 32'd0);
        check_output({tag, "_addr"},  32'(mem_addr), 32'd0);
        check_output({tag, "_pout"},  32'(pattern_out), 32'd0);
        check_output({tag, "_pv"},    32'(pattern_valid), 32'd0);
        check_output({tag, "_done"},  32'(done), 32'd0);
        check_output({tag, "_hit"},   32'(hit_count), 32'd0);
        check_output({tag, "_miss"},  32'(miss_count), 32'd0);
        check_output({tag, "_fault"}, 32'(fault), 32'd0);
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        while (mem_rd !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_output(tag, 32'(mem_rd), 32'd1);
    endtask

    task automatic wait_rd2(input string tag);
        int n = 0;
        while (mem_rd2 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_output(tag, 32'(mem_rd2), 32'd1);
    endtask

    // Called in the FETCH cycle; returns in the cycle after mem_valid is sampled.
    task automatic serve(input logic [31:0] word);
        step();
        mem_valid = 1'b1;
        read_data = word;
        step();
        mem_valid = 1'b0;
    endtask

    task automatic serve2(input logic [31:0] word);
        step();
        mem_valid2 = 1'b1;
        read_data2 = word;
        step();
        mem_valid2 = 1'b0;
    endtask

    initial begin
        $display("[TB] pattern_sequencer directed bench");
        step();
        step();
        RESET_N = 1'b1;
        check_reset("reset");

        // three steps of delay 2, key echoes each pattern, then the end marker
        start = 1'b1;
        step();
        start = 1'b0;
        check_output("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            wait_rd($sformatf("t1_rd%0d", i));
            check_output($sformatf("t1_addr%0d", i), 32'(mem_addr), 32'(i));
            serve({24'd2, pats[i]});
            step();
            counter10h = 1'b1;
            step();
            counter10h = 1'b0;
            check_output($sformatf("t1_pv_tick1_%0d", i), 32'(pattern_valid), 32'd0);
            step();
            counter10h = 1'b1;
            step();
            counter10h = 1'b0;
            check_output($sformatf("t1_pv_tick2_%0d", i), 32'(pattern_valid), 32'd0);
            step();
            check_output($sformatf("t1_pv%0d", i), 32'(pattern_valid), 32'd1);
            check_output($sformatf("t1_pout%0d", i), 32'(pattern_out), 32'(pats[i]));
            user_key = pats[i];
            step();
            user_key = 8'h00;
            check_output($sformatf("t1_hit%0d", i), 32'(hit_count), 32'(i + 1));
            check_output($sformatf("t1_pv_off%0d", i), 32'(pattern_valid), 32'd0);
            step();
        end
        wait_rd("t1_rd_marker");
        check_output("t1_addr_marker", 32'(mem_addr), 32'd3);
        serve(32'h0000_FFFF);
        check_output("t1_done", 32'(done), 32'd1);
        check_output("t1_idle", 32'(busy), 32'd0);
        check_output("t1_hits", 32'(hit_count), 32'd3);
        check_output("t1_miss", 32'(miss_count), 32'd0);
        step();
        check_output("t1_done_pulse", 32'(done), 32'd0);
        check_output("t1_pout_hold", 32'(pattern_out), 32'h3C);

        // pattern 0xA5 with key held at 0: miss after exactly five ticks
        start = 1'b1;
        step();
        start = 1'b0;
        check_output("t2_rd", 32'(mem_rd), 32'd1);
        check_output("t2_addr", 32'(mem_addr), 32'd0);
        check_output("t2_hit_clr", 32'(hit_count), 32'd0);
        check_output("t2_pout_clr", 32'(pattern_out), 32'd0);
        serve({24'd0, 8'hA5});
        step();
        check_output("t2_pv", 32'(pattern_valid), 32'd1);
        check_output("t2_pout", 32'(pattern_out), 32'hA5);
        step();
        for (int k = 0; k < 5; k++) begin
            counter10h = 1'b1;
            step();
            counter10h = 1'b0;
            if (k < 4) begin
                check_output($sformatf("t2_win%0d", k), 32'(miss_count), 32'd0);
                step();
            end
        end
        check_output("t2_miss", 32'(miss_count), 32'd1);
        check_output("t2_hit", 32'(hit_count), 32'd0);
        step();
        check_output("t2_next_rd", 32'(mem_rd), 32'd1);
        check_output("t2_next_addr", 32'(mem_addr), 32'd1);

        // abort during DELAY
        serve({24'd3, 8'h11});
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_output("t3_busy", 32'(busy), 32'd0);
        check_output("t3_pout", 32'(pattern_out), 32'd0);
        check_output("t3_miss_kept", 32'(miss_count), 32'd1);
        mem_valid = 1'b1;
        read_data = {24'd0, 8'h22};
        step();
        mem_valid = 1'b0;
        step();
        check_output("t3_stray_busy", 32'(busy), 32'd0);
        check_output("t3_stray_pv", 32'(pattern_valid), 32'd0);

        // abort in the same cycle as mem_valid
        start = 1'b1;
        step();
        start = 1'b0;
        check_output("t3b_miss_clr", 32'(miss_count), 32'd0);
        step();
        mem_valid = 1'b1;
        read_data = {24'd0, 8'h77};
        abort     = 1'b1;
        step();
        mem_valid = 1'b0;
        abort     = 1'b0;
        check_output("t3b_busy", 32'(busy), 32'd0);
        check_output("t3b_done", 32'(done), 32'd0);
        step();
        step();
        check_output("t3b_pv", 32'(pattern_valid), 32'd0);
        check_output("t3b_pout", 32'(pattern_out), 32'd0);
        check_output("t3b_idle", 32'(busy), 32'd0);

        // reset pulse during SHOW, then a stale mem_valid
        start = 1'b1;
        step();
        start = 1'b0;
        serve({24'd0, 8'h5A});
        step();
        user_key = 8'h5A;
        step();
        user_key = 8'h00;
        step();
        serve({24'd0, 8'hC3});
        step();
        check_output("t4_hit_pre", 32'(hit_count), 32'd1);
        check_output("t4_pout_pre", 32'(pattern_out), 32'hC3);
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        check_reset("t4");
        mem_valid = 1'b1;
        read_data = {24'd0, 8'h99};
        step();
        mem_valid = 1'b0;
        step();
        step();
        check_output("t4_stale_busy", 32'(busy), 32'd0);
        check_output("t4_stale_pv", 32'(pattern_valid), 32'd0);
        check_output("t4_stale_pout", 32'(pattern_out), 32'd0);

        // 300 zero-delay steps, key always matching: hit_count saturates
        user_key = 8'h42;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            wait_rd($sformatf("t5_rd%0d", i));
            if (i == 260)
                check_output("t5_sat_mid", 32'(hit_count), 32'd255);
            serve({24'd0, 8'h42});
        end
        wait_rd("t5_rd_marker");
        serve(32'h0000_FFFF);
        check_output("t5_done", 32'(done), 32'd1);
        check_output("t5_sat", 32'(hit_count), 32'd255);
        check_output("t5_miss", 32'(miss_count), 32'd0);
        check_output("t5_fault", 32'(fault), 32'd0);

        // two-bit address space with no marker: fault after four fetches
        user_key = 8'h0F;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int a = 0; a < 4; a++) begin
            wait_rd2($sformatf("t6_rd%0d", a));
            check_output($sformatf("t6_addr%0d", a), 32'(mem_addr2), 32'(a));
            serve2({24'd0, 8'h0F});
        end
        step();
        step();
        check_output("t6_next_busy", 32'(busy2), 32'd1);
        check_output("t6_next_done", 32'(done2), 32'd0);
        step();
        check_output("t6_fault", 32'(fault2), 32'd1);
        check_output("t6_idle", 32'(busy2), 32'd0);
        check_output("t6_no_done", 32'(done2), 32'd0);
        check_output("t6_no_rd", 32'(mem_rd2), 32'd0);
        check_output("t6_hits", 32'(hit_count2), 32'd4);
        user_key = 8'h00;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check_output("t6_fault_clr", 32'(fault2), 32'd0);
        check_output("t6_restart_addr", 32'(mem_addr2), 32'd0);
        check_output("t6_restart_rd", 32'(mem_rd2), 32'd1);
        abort2 = 1'b1;
        step();
        abort2 = 1'b0;
        check_output("t6_abort", 32'(busy2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Fetches a timed LED/key pattern from pattern memory word by word and plays it back on the 10 Hz tick. Each step is judged against the user's key input within a response window. Playback stops on the end-of-pattern marker. The block sits between the pattern memory read port and the pattern display/input logic, and sequences the full playback run that the input path consumes.

## Interface
- ADDR_W, 10, pattern memory address width
- BASE_ADDR, 0, address of the first pattern word
- WINDOW, 5, response window length in counter10h ticks (≥1)

- CLOCK10M  in  1  system clock, 10 MHz
- RESET_N  in  1  reset, synchronous, active-low
- counter10h  in  1  one-cycle pulse at 10 Hz
- start  in  1  begin playback; honoured only in IDLE
- abort  in  1  stop playback; honoured in any state
- mem_addr  out  ADDR_W  pattern memory word address
- mem_rd  out  1  one-cycle read request
- mem_valid  in  1  read_data valid; sampled only in WAIT_DATA
- read_data  in  32  memory word: [31:8] delay in ticks, [7:0] pattern
- user_key  in  8  current key state, already synchronised
- pattern_out  out  8  currently displayed pattern
- pattern_valid  out  1  one-cycle pulse when a new pattern is emitted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the end marker is reached
- hit_count  out  8  steps matched, saturating at 255
- miss_count  out  8  steps missed, saturating at 255
- fault  out  1  sticky flag: address space exhausted with no end marker

## Operation
- States: IDLE, FETCH, WAIT_DATA, DELAY, SHOW, NEXT.
- IDLE:
  - When start=1, go to FETCH.
  - Load mem_addr=BASE_ADDR.
  - Clear hit_count, miss_count, fault and pattern_out.
- FETCH: assert mem_rd for exactly one cycle, then go to WAIT_DATA.
- WAIT_DATA:
  - Wait for mem_valid, with no timeout.
  - When mem_valid=1 and read_data==32'h0000FFFF (the end marker), pulse done and go to IDLE. The marker is matched exactly and takes precedence, so delay 0xFF with pattern 0xFF cannot be encoded as a step.
  - On any other word, latch delay=read_data[31:8] and pat=read_data[7:0], then go to DELAY.
- DELAY:
  - Count counter10h pulses.
  - When count==delay, go to SHOW. delay=0 goes to SHOW the next cycle.
- SHOW:
  - On entry, set pattern_out=pat, pulse pattern_valid and clear the window counter.
  - Hit: any cycle with user_key==pat. Increment hit_count and go to NEXT.
  - Miss: WINDOW counter10h pulses elapse with no match. Increment miss_count and go to NEXT.
  - If both happen on the same cycle, the hit wins.
- NEXT:
  - If mem_addr is all ones, set fault and go to IDLE with no done pulse.
  - Otherwise increment mem_addr and go to FETCH.
- pattern_out holds its value until the next emission, or is cleared by start, abort or reset.
- abort=1 in any state:
  - Go to IDLE on the next cycle and clear pattern_out.
  - Counters and fault keep their values; no done pulse.
  - abort takes priority over start, mem_valid and window events in the same cycle.
- start while busy is ignored.
- Counters saturate at 255 and never wrap.

## Timing
- Reset (RESET_N=0 at a clock edge) forces:
  - state IDLE; mem_addr=BASE_ADDR
  - mem_rd=0, pattern_out=0, pattern_valid=0, busy=0, done=0
  - hit_count=0, miss_count=0, fault=0
- Reset mid-playback behaves the same; a read already in flight is dropped and a later mem_valid is ignored.
- start sampled at edge N gives busy=1 and mem_rd=1 during cycle N+1.
- mem_valid at edge M with delay=0 gives pattern_valid during cycle M+2 (M+1: DELAY, M+2: SHOW entry).
- A hit detected at edge H gives mem_rd during cycle H+2 (H+1: NEXT).
- A counter10h pulse in the same cycle as the DELAY entry is not counted.
- mem_valid outside WAIT_DATA is ignored.
- Every pulse output (mem_rd, pattern_valid, done) is exactly one cycle wide.

## Test plan
- Three steps of delay 2, then the marker; user_key echoes each pattern one cycle after pattern_valid. Required: three pattern_valid pulses each 2 ticks after its data, hit_count=3, miss_count=0, one done pulse, busy=0.
- One step with pattern 0xA5 and user_key held at 0x00. Required: after exactly WINDOW=5 ticks, miss_count=1, then the next fetch happens at BASE_ADDR+1.
- ADDR_W=2 with no marker in memory. Required: four fetches at addresses 0–3, fault=1, no done pulse, return to IDLE; the next start clears fault.
- abort asserted during DELAY, and separately in the same cycle as mem_valid. Required: IDLE on the next cycle, pattern_out=0, counts retained, data ignored.
- RESET_N low for one cycle during SHOW, then a stale mem_valid. Required: all outputs at their reset values and no state change.
- 300 steps of delay 0 with the key always matching. Required: hit_count saturates at 255.
